// File: rtl/button_debounce8.sv
// ============================================================================
// Module   : button_debounce8
// Brief    : N-channel push-button conditioner: 2-FF synchroniser, shared
//            sample-tick prescaler, per-channel stability counter, and
//            one-cycle press/release pulses.
// Options  : DEBOUNCE_ACTIVE_LOW_EN - invert raw_in for pull-up buttons.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce8 #(
  parameter int N          = 8,
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] clean,
  output logic [N-1:0] press,
  output logic [N-1:0] rel,
  output logic         any_pressed
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);

  logic [N-1:0]  raw_lvl;
  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [N-1:0]  clean_nxt;
  logic [PW-1:0] pcnt;
  logic          tick;
  logic [CW-1:0] cnt     [N];
  logic [CW-1:0] cnt_nxt [N];

  // Polarity is normalised before the synchroniser so everything after it
  // sees pressed = 1.
`ifdef DEBOUNCE_ACTIVE_LOW_EN
  assign raw_lvl = ~raw_in;
`else
  assign raw_lvl = raw_in;
`endif

  assign tick = (pcnt == TICK_LAST);

  always_comb begin
    clean_nxt = clean;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = cnt[i];
      if (tick) begin
        if (s2[i] == clean[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          clean_nxt[i] = s2[i];
          cnt_nxt[i]   = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      pcnt        <= '0;
      clean       <= '0;
      press       <= '0;
      rel         <= '0;
      any_pressed <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1          <= raw_lvl;
      s2          <= s1;
      pcnt        <= tick ? '0 : pcnt + 1'b1;
      clean       <= clean_nxt;
      press       <= clean_nxt & ~clean;
      rel         <= ~clean_nxt & clean;
      any_pressed <= |clean_nxt;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_button_debounce8.sv
// ============================================================================
// Module   : tb_button_debounce8
// Brief    : Directed self-checking bench for button_debounce8
//            (TICK_DIV=4, STABLE_CNT=3, N=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debounce8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] raw_in = 8'h00;
  logic [7:0] clean, press, rel;
  logic       any_pressed;

  int checks = 0;
  int errors = 0;

`ifdef DEBOUNCE_ACTIVE_LOW_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  button_debounce8 #(.N(8), .TICK_DIV(4), .STABLE_CNT(3)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .clean(clean),
    .press(press), .rel(rel), .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock, then settle past the edge before looking at outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the logical (pressed = 1) level; the bench applies board polarity.
  task automatic press_lvl(input logic [7:0] lvl);
    raw_in = lvl ^ INV;
  endtask

  task automatic wait_clean(input string tag, input logic [7:0] target,
                            input int limit, output int n);
    n = 0;
    while (clean !== target && n < limit) begin
      step();
      n++;
    end
    if (clean !== target) check({tag, "_timeout"}, clean, target);
  endtask

  task automatic wait_change(input string tag, input logic [7:0] from,
                             input int limit);
    int n = 0;
    while (clean === from && n < limit) begin
      step();
      n++;
    end
    if (clean === from) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] seen;

    // 1: reset with all buttons down, then release reset
    press_lvl(8'hFF);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_outs", {clean, press, rel, 7'b0, any_pressed}, 32'h0);
    end
    reset = 1'b0;
    wait_clean("t1", 8'hFF, 30, n);
    check("t1_latency", n, 12);
    check("t1_press", press, 8'hFF);
    check("t1_any", any_pressed, 1'b1);
    step();
    check("t1_press_once", press, 8'h00);

    press_lvl(8'h00);
    wait_clean("t1r", 8'h00, 30, n);
    check("t1_rel", rel, 8'hFF);
    check("t1_any_off", any_pressed, 1'b0);
    step();
    check("t1_rel_once", rel, 8'h00);

    // 2: single button held
    press_lvl(8'h01);
    wait_change("t2", 8'h00, 30);
    check("t2_clean", clean, 8'h01);
    check("t2_press", press, 8'h01);
    check("t2_any", any_pressed, 1'b1);
    seen = 8'h00;
    for (int i = 0; i < 24; i++) begin
      step();
      seen |= press | rel;
    end
    check("t2_no_pulses", seen, 8'h00);
    check("t2_hold", clean, 8'h01);

    press_lvl(8'h00);
    wait_clean("t2r", 8'h00, 30, n);
    for (int i = 0; i < 16; i++) step();

    // 3: 8-cycle glitch spans exactly two ticks; repeat after a low gap to
    //    prove the bounce discarded the earlier progress
    seen = 8'h00;
    for (int r = 0; r < 2; r++) begin
      press_lvl(8'h20);
      for (int i = 0; i < 8; i++) begin step(); seen |= clean | press; end
      press_lvl(8'h00);
      for (int i = 0; i < 16; i++) begin step(); seen |= clean | press; end
    end
    check("t3_glitch", seen, 8'h00);

    // 4: two buttons at once
    press_lvl(8'h81);
    wait_change("t4", 8'h00, 30);
    check("t4_clean", clean, 8'h81);
    check("t4_press", press, 8'h81);
    step();
    check("t4_press_once", press, 8'h00);

    // 5: staged release
    press_lvl(8'h80);
    wait_change("t5", 8'h81, 30);
    check("t5_clean", clean, 8'h80);
    check("t5_rel", rel, 8'h01);
    check("t5_press", press, 8'h00);
    check("t5_any", any_pressed, 1'b1);
    press_lvl(8'h00);
    wait_change("t5b", 8'h80, 30);
    check("t5b_clean", clean, 8'h00);
    check("t5b_rel", rel, 8'h80);
    check("t5b_any", any_pressed, 1'b0);
    for (int i = 0; i < 16; i++) step();

    // 6: reset in the middle of a qualification, button stays held
    press_lvl(8'h01);
    for (int i = 0; i < 10; i++) step();
    check("t6_pre", clean, 8'h00);
    reset = 1'b1;
    step();
    check("t6_rst", {clean, press, rel, 7'b0, any_pressed}, 32'h0);
    reset = 1'b0;
    wait_clean("t6", 8'h01, 30, n);
    check("t6_latency", n, 12);
    check("t6_press", press, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
